// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA Montgomery multiplier arbitration slice.
package rsa_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_LOAD,
        ARB_RUN,
        ARB_CAPTURE,
        ARB_DONE
    } arb_state_t;

    localparam int RSA_WIDTH = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after rr_ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   rr_ptr,
    output logic [OW-1:0]   winner,
    output logic            any_req
);

    logic [OW-1:0] idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = OW'((int'(rr_ptr) + i) % NREQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

endmodule

// File: rtl/rsa_mmm_arbiter.sv
// Shares one Montgomery multiplier between NREQ requesters and sequences
// load, WIDTH step cycles and result capture for the granted owner.
module rsa_mmm_arbiter
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    input  logic [NREQ*WIDTH-1:0] m_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  mmm_run,
    output logic                  mmm_ld_a,
    output logic [WIDTH-1:0]      mmm_a,
    output logic [WIDTH-1:0]      mmm_b,
    output logic [WIDTH-1:0]      mmm_m,
    input  logic [WIDTH-1:0]      mmm_r
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Handshake: req is a level sampled only in IDLE; gnt[i] stays high from
    // LOAD through DONE, operands must be stable meanwhile; done[i] pulses in
    // DONE (stretched while ena is low). Dropping req mid-job does not abort.

    arb_state_t    state;
    logic [OW-1:0] owner;
    logic [OW-1:0] rr_ptr;
    logic [CW-1:0] cnt;
    logic [OW-1:0] winner;
    logic          any_req;
    logic [OW-1:0] owner_next;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign owner_next = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (ena) begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        owner <= winner;
                        state <= ARB_LOAD;
                    end
                end
                ARB_LOAD: begin
                    cnt   <= '0;
                    state <= ARB_RUN;
                end
                ARB_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1))
                        state <= ARB_CAPTURE;
                end
                ARB_CAPTURE: begin
                    result <= mmm_r;
                    state  <= ARB_DONE;
                end
                ARB_DONE: begin
                    rr_ptr <= owner_next;
                    state  <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Control outputs decode the registered state, so they freeze with ena.
    always_comb begin
        gnt      = '0;
        done     = '0;
        mmm_run  = 1'b0;
        mmm_ld_a = 1'b0;
        case (state)
            ARB_LOAD: begin
                gnt[owner] = 1'b1;
                mmm_run    = 1'b1;
                mmm_ld_a   = 1'b1;
            end
            ARB_RUN, ARB_CAPTURE: begin
                gnt[owner] = 1'b1;
                mmm_run    = 1'b1;
            end
            ARB_DONE: begin
                gnt[owner]  = 1'b1;
                done[owner] = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        mmm_a = '0;
        mmm_b = '0;
        mmm_m = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == OW'(i)) begin
                mmm_a = a_in[i*WIDTH +: WIDTH];
                mmm_b = b_in[i*WIDTH +: WIDTH];
                mmm_m = m_in[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_rsa_mmm_arbiter.sv
// Directed bench for rsa_mmm_arbiter (WIDTH=8, NREQ=2) with a small MMM timing model.
module tb_rsa_mmm_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 2;

    logic                  clk;
    logic                  rst;
    logic                  ena;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ*WIDTH-1:0] m_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  mmm_run;
    logic                  mmm_ld_a;
    logic [WIDTH-1:0]      mmm_a;
    logic [WIDTH-1:0]      mmm_b;
    logic [WIDTH-1:0]      mmm_m;
    logic [WIDTH-1:0]      mmm_r;

    int errors = 0;
    int checks = 0;

    // MMM model: result only appears in the cycle after the last step.
    logic [WIDTH-1:0] res_val;
    int               steps;

    rsa_mmm_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .m_in     (m_in),
        .gnt      (gnt),
        .done     (done),
        .result   (result),
        .mmm_run  (mmm_run),
        .mmm_ld_a (mmm_ld_a),
        .mmm_a    (mmm_a),
        .mmm_b    (mmm_b),
        .mmm_m    (mmm_m),
        .mmm_r    (mmm_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mmm_run) steps <= 0;
        else if (ena) steps <= steps + 1;
    end
    assign mmm_r = (steps == WIDTH + 1) ? res_val : 8'hEE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", done); end
        checks++; if (mmm_run !== 1'b0) begin errors++; $display("FAIL reset_run got %b want 0", mmm_run); end
        checks++; if (mmm_ld_a !== 1'b0) begin errors++; $display("FAIL reset_ld got %b want 0", mmm_ld_a); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", result); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [1:0] eg, ed;
        logic       er, el;
        res_val = 8'h3C;
        a_in = {8'h00, 8'd5};
        b_in = {8'h00, 8'd7};
        m_in = {8'h00, 8'd11};
        req  = 2'b01;
        for (int c = 0; c <= 12; c++) begin
            eg = (c >= 1 && c <= 11) ? 2'b01 : 2'b00;
            ed = (c == 11) ? 2'b01 : 2'b00;
            er = (c >= 1 && c <= 10);
            el = (c == 1);
            checks++; if (gnt !== eg) begin errors++; $display("FAIL single_gnt c%0d got %b want %b", c, gnt, eg); end
            checks++; if (done !== ed) begin errors++; $display("FAIL single_done c%0d got %b want %b", c, done, ed); end
            checks++; if (mmm_run !== er) begin errors++; $display("FAIL single_run c%0d got %b want %b", c, mmm_run, er); end
            checks++; if (mmm_ld_a !== el) begin errors++; $display("FAIL single_ld c%0d got %b want %b", c, mmm_ld_a, el); end
            if (c == 1) begin
                checks++;
                if ({mmm_a, mmm_b, mmm_m} !== {8'd5, 8'd7, 8'd11}) begin
                    errors++; $display("FAIL single_ops got %h/%h/%h want 05/07/0b", mmm_a, mmm_b, mmm_m);
                end
            end
            if (c == 11) begin
                checks++; if (result !== 8'h3C) begin errors++; $display("FAIL single_result got %h want 3c", result); end
            end
            tick();
            if (c == 0) req = 2'b00;
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] eg, ed;
        int         p, k;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        res_val = 8'h11;
        req = 2'b11;
        for (int c = 0; c < 36; c++) begin
            p  = c % 12;
            k  = c / 12;
            eg = (p >= 1) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            ed = (p == 11) ? eg : 2'b00;
            checks++; if (gnt !== eg) begin errors++; $display("FAIL simul_gnt c%0d got %b want %b", c, gnt, eg); end
            checks++; if (done !== ed) begin errors++; $display("FAIL simul_done c%0d got %b want %b", c, done, ed); end
            checks++;
            if ((done & ~gnt) !== 2'b00 || done === 2'b11 || gnt === 2'b11) begin
                errors++; $display("FAIL simul_onehot c%0d got gnt=%b done=%b want onehot", c, gnt, done);
            end
            tick();
        end
        req = 2'b00;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL simul_idle got %b want 00", gnt); end
        tick();
    endtask

    task automatic test_drop();
        logic [1:0] eg, ed;
        req = 2'b10;
        for (int c = 0; c <= 13; c++) begin
            if (c == 4) req = 2'b00;
            eg = (c >= 1 && c <= 11) ? 2'b10 : 2'b00;
            ed = (c == 11) ? 2'b10 : 2'b00;
            checks++; if (gnt !== eg) begin errors++; $display("FAIL drop_gnt c%0d got %b want %b", c, gnt, eg); end
            checks++; if (done !== ed) begin errors++; $display("FAIL drop_done c%0d got %b want %b", c, done, ed); end
            tick();
        end
    endtask

    task automatic test_operand_mux();
        a_in = {8'hA5, 8'h00};
        req  = 2'b10;
        for (int c = 0; c <= 12; c++) begin
            a_in[7:0] = 8'($urandom_range(0, 255));
            #1;
            if (c >= 1 && c <= 11) begin
                checks++;
                if (mmm_a !== 8'hA5) begin errors++; $display("FAIL mux_a c%0d got %h want a5", c, mmm_a); end
            end
            tick();
            if (c == 0) req = 2'b00;
        end
    endtask

    task automatic test_reset_mid();
        res_val = 8'h3C;
        a_in = {8'h00, 8'd5};
        req = 2'b01;
        for (int c = 0; c <= 5; c++) begin
            checks++; if (done !== 2'b00) begin errors++; $display("FAIL rstmid_done c%0d got %b want 00", c, done); end
            if (c == 5) rst = 1'b1;
            tick();
        end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rstmid_gnt got %b want 00", gnt); end
        checks++; if (mmm_run !== 1'b0) begin errors++; $display("FAIL rstmid_run got %b want 0", mmm_run); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL rstmid_result got %h want 00", result); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL rstmid_nodone got %b want 00", done); end
        rst = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            checks++;
            if (done !== ((c == 11) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL rstmid_redone c%0d got %b want %b", c, done, (c == 11) ? 2'b01 : 2'b00);
            end
            if (c == 11) begin
                checks++; if (result !== 8'h3C) begin errors++; $display("FAIL rstmid_reresult got %h want 3c", result); end
            end
            tick();
            if (c == 0) req = 2'b00;
        end
    endtask

    task automatic test_ena();
        logic [1:0] eg, ed;
        logic       er;
        int         e;
        res_val = 8'h5A;
        req = 2'b01;
        for (int c = 0; c <= 15; c++) begin
            e  = (c <= 4) ? c : ((c <= 7) ? 4 : c - 3);
            eg = (e >= 1 && e <= 11) ? 2'b01 : 2'b00;
            ed = (e == 11) ? 2'b01 : 2'b00;
            er = (e >= 1 && e <= 10);
            checks++; if (gnt !== eg) begin errors++; $display("FAIL ena_gnt c%0d got %b want %b", c, gnt, eg); end
            checks++; if (done !== ed) begin errors++; $display("FAIL ena_done c%0d got %b want %b", c, done, ed); end
            checks++; if (mmm_run !== er) begin errors++; $display("FAIL ena_run c%0d got %b want %b", c, mmm_run, er); end
            if (c == 14) begin
                checks++; if (result !== 8'h5A) begin errors++; $display("FAIL ena_result got %h want 5a", result); end
            end
            ena = !(c >= 4 && c <= 6);
            tick();
            ena = 1'b1;
            if (c == 0) req = 2'b00;
        end
    endtask

    initial begin
        rst     = 1'b1;
        ena     = 1'b1;
        req     = 2'b00;
        a_in    = '0;
        b_in    = '0;
        m_in    = '0;
        res_val = 8'h00;
        test_reset();
        test_single();
        test_simultaneous();
        test_drop();
        test_operand_mux();
        test_reset_mid();
        test_ena();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
